// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Tracks the destination registers of the DEPTH youngest in-flight producer
// stages and, for each decode-stage source port, picks the forwarding source
// (register file or stage k). A port whose youngest matching producer is a
// load that is not yet ready raises stall; the stalled instruction is held in
// decode while a bubble enters stage 1.
//
// Ports
//   clk           single clock, rising edge
//   reset_n       asynchronous active-low reset
//   dec_valid     decode stage holds a real instruction
//   dec_ra        source addresses, port i at [i*AW +: AW]
//   dec_rd_en     port i actually reads its register
//   dec_aw        destination register of the decode instruction
//   dec_wr_en     decode instruction writes dec_aw
//   dec_is_load   decode instruction is a load
//   flush         squash every tracked in-flight producer
//   fwd_sel       per port: 0 = register file, k = forward from stage k
//   stall         hold decode, insert a bubble into stage 1
//   stall_cycles  saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int NUM_RD   = 2,
  parameter int DEPTH    = 2,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31,
  parameter int LOAD_LAT = 1,
  localparam int SW      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 dec_valid,
  input  logic [NUM_RD*AW-1:0] dec_ra,
  input  logic [NUM_RD-1:0]    dec_rd_en,
  input  logic [AW-1:0]        dec_aw,
  input  logic                 dec_wr_en,
  input  logic                 dec_is_load,
  input  logic                 flush,
  output logic [NUM_RD*SW-1:0] fwd_sel,
  output logic                 stall,
  output logic [15:0]          stall_cycles
);

  // Readiness counter is at least one bit wide even when loads are never late.
  localparam int RCW = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  typedef struct packed {
    logic           v;
    logic [AW-1:0]  aw;
    logic [RCW-1:0] rdy;
  } stage_t;

  // stg[0] is stage 1 (Exec, youngest), stg[DEPTH-1] is the oldest tracked.
  stage_t stg [DEPTH];

  logic [NUM_RD-1:0] hazard;

  // ---------------------------------------------------------------------------
  // Forward select / hazard detection (zero-cycle, purely combinational)
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    fwd_sel = '0;
    hazard  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      // Scan oldest to youngest so the youngest match overwrites older ones;
      // an unready youngest producer is never bypassed by an older stage.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (dec_rd_en[i] && stg[k].v &&
            (stg[k].aw == dec_ra[i*AW +: AW]) &&
            (dec_ra[i*AW +: AW] != ZERO_ADDR)) begin
          fwd_sel[i*SW +: SW] = SW'(k + 1);
          hazard[i]           = (stg[k].rdy != '0);
        end
      end
    end
    if (!dec_valid) begin
      fwd_sel = '0;
    end
  end

  assign stall = dec_valid & (|hazard) & ~flush;

  // ---------------------------------------------------------------------------
  // Producer pipeline and stall counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the stage array is tiny control state whose valid bits must be
      // known after reset, so every entry is cleared rather than left as a
      // reset-less memory.
      for (int k = 0; k < DEPTH; k++) begin
        stg[k] <= '0;
      end
      stall_cycles <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every stage samples the
      // pre-edge value of its neighbour, giving a true shift register.
      if (stall && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end

      if (flush) begin
        for (int k = 0; k < DEPTH; k++) begin
          stg[k].v <= 1'b0;
        end
      end else begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          stg[k].v   <= stg[k-1].v;
          stg[k].aw  <= stg[k-1].aw;
          stg[k].rdy <= (stg[k-1].rdy != '0) ? stg[k-1].rdy - 1'b1 : '0;
        end
        // A stalled instruction stays in decode; stage 1 takes a bubble and
        // the instruction is captured on its first non-stalled cycle.
        stg[0].v   <= dec_valid & dec_wr_en & (dec_aw != ZERO_ADDR) & ~stall;
        stg[0].aw  <= dec_aw;
        stg[0].rdy <= dec_is_load ? RCW'(LOAD_LAT) : '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Directed bench for hazard_forward_unit. u_dut uses the default parameters
// and walks the forwarding, load-use, zero-register, youngest-wins, flush and
// reset scenarios. u_big (DEPTH=7, LOAD_LAT=6) stalls six of every seven
// cycles on a self-dependent load and drives stall_cycles into saturation.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

  logic        clk;
  logic        reset_n;

  // Default-parameter instance stimulus / observation
  logic        dec_valid;
  logic [9:0]  dec_ra;
  logic [1:0]  dec_rd_en;
  logic [4:0]  dec_aw;
  logic        dec_wr_en;
  logic        dec_is_load;
  logic        flush;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_cycles;

  // Saturation instance
  logic        b_valid;
  logic [5:0]  b_fwd_sel;
  logic        b_stall;
  logic [15:0] b_stall_cycles;

  int vectors     = 0;
  int miscompares = 0;

  hazard_forward_unit u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dec_valid    (dec_valid),
    .dec_ra       (dec_ra),
    .dec_rd_en    (dec_rd_en),
    .dec_aw       (dec_aw),
    .dec_wr_en    (dec_wr_en),
    .dec_is_load  (dec_is_load),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .stall_cycles (stall_cycles)
  );

  // LDUR X3,[X3] held in decode forever: reads and writes X3.
  hazard_forward_unit #(.DEPTH(7), .LOAD_LAT(6)) u_big (
    .clk          (clk),
    .reset_n      (reset_n),
    .dec_valid    (b_valid),
    .dec_ra       (10'd3),
    .dec_rd_en    (2'b01),
    .dec_aw       (5'd3),
    .dec_wr_en    (1'b1),
    .dec_is_load  (1'b1),
    .flush        (1'b0),
    .fwd_sel      (b_fwd_sel),
    .stall        (b_stall),
    .stall_cycles (b_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r0,
                       input logic [1:0] en, input logic [4:0] a, input logic we,
                       input logic ld, input logic fl);
    dec_valid   = v;
    dec_ra      = {r1, r0};
    dec_rd_en   = en;
    dec_aw      = a;
    dec_wr_en   = we;
    dec_is_load = ld;
    flush       = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    b_valid = 1'b0;
    drive(1, 5'd1, 5'd1, 2'b11, 5'd1, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fwd_sel", 32'(fwd_sel), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_stall_cycles", 32'(stall_cycles), 32'd0);
    reset_n = 1'b1;

    // ADD X1, X5, X6
    drive(1, 5'd6, 5'd5, 2'b11, 5'd1, 1, 0, 0);
    @(negedge clk);
    chk("add_x1_fwd", 32'(fwd_sel), 32'd0);
    chk("add_x1_stall", 32'(stall), 32'd0);
    next_cycle();

    // ADD X2, X1, X1 : both ports forward from stage 1
    drive(1, 5'd1, 5'd1, 2'b11, 5'd2, 1, 0, 0);
    @(negedge clk);
    chk("add_x2_fwd", 32'(fwd_sel), 32'b0101);
    chk("add_x2_stall", 32'(stall), 32'd0);
    next_cycle();

    // Reader: port0 X1 (stage 2), port1 X2 (stage 1), no write
    drive(1, 5'd2, 5'd1, 2'b11, 5'd0, 0, 0, 0);
    @(negedge clk);
    chk("rd_x1_x2_fwd", 32'(fwd_sel), 32'b0110);
    chk("rd_x1_x2_stall", 32'(stall), 32'd0);
    next_cycle();

    // dec_valid low: no forwarding even though X2 sits in stage 2
    drive(0, 5'd2, 5'd2, 2'b11, 5'd7, 1, 0, 0);
    @(negedge clk);
    chk("invalid_fwd", 32'(fwd_sel), 32'd0);
    chk("invalid_stall", 32'(stall), 32'd0);
    next_cycle();

    // LDUR X3
    drive(1, 5'd0, 5'd0, 2'b00, 5'd3, 1, 1, 0);
    @(negedge clk);
    chk("ldur_x3_stall", 32'(stall), 32'd0);
    next_cycle();

    // Reader of X3 on port1 (writes X8): load-use stall
    drive(1, 5'd3, 5'd0, 2'b10, 5'd8, 1, 0, 0);
    @(negedge clk);
    chk("loaduse_stall", 32'(stall), 32'd1);
    chk("loaduse_fwd", 32'(fwd_sel), 32'b0100);
    chk("loaduse_cnt_before", 32'(stall_cycles), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("loaduse_retry_stall", 32'(stall), 32'd0);
    chk("loaduse_retry_fwd", 32'(fwd_sel), 32'b1000);
    chk("loaduse_cnt_after", 32'(stall_cycles), 32'd1);
    next_cycle();

    // Write to X31 (never tracked)
    drive(1, 5'd0, 5'd0, 2'b00, 5'd31, 1, 0, 0);
    @(negedge clk);
    chk("wr_x31_stall", 32'(stall), 32'd0);
    next_cycle();

    // Read X31 on both ports; X8 is still in stage 2
    drive(1, 5'd31, 5'd31, 2'b11, 5'd0, 0, 0, 0);
    @(negedge clk);
    chk("rd_x31_fwd", 32'(fwd_sel), 32'd0);
    chk("rd_x31_stall", 32'(stall), 32'd0);
    next_cycle();

    // ADD X4 then LDUR X4, then read X4: youngest (unready load) wins
    drive(1, 5'd0, 5'd0, 2'b00, 5'd4, 1, 0, 0);
    next_cycle();
    drive(1, 5'd0, 5'd0, 2'b00, 5'd4, 1, 1, 0);
    next_cycle();
    drive(1, 5'd4, 5'd4, 2'b11, 5'd0, 0, 0, 0);
    @(negedge clk);
    chk("youngest_stall", 32'(stall), 32'd1);
    chk("youngest_fwd", 32'(fwd_sel), 32'b0101);
    next_cycle();
    @(negedge clk);
    chk("youngest_retry_stall", 32'(stall), 32'd0);
    chk("youngest_retry_fwd", 32'(fwd_sel), 32'b1010);
    chk("youngest_cnt", 32'(stall_cycles), 32'd2);
    next_cycle();

    // LDUR X3, then reader of X3 together with flush
    drive(1, 5'd0, 5'd0, 2'b00, 5'd3, 1, 1, 0);
    next_cycle();
    drive(1, 5'd3, 5'd3, 2'b11, 5'd9, 1, 0, 1);
    @(negedge clk);
    chk("flush_stall", 32'(stall), 32'd0);
    next_cycle();
    drive(1, 5'd9, 5'd3, 2'b11, 5'd0, 0, 0, 0);
    @(negedge clk);
    chk("post_flush_fwd", 32'(fwd_sel), 32'd0);
    chk("post_flush_stall", 32'(stall), 32'd0);
    chk("post_flush_cnt", 32'(stall_cycles), 32'd2);
    next_cycle();

    // Saturation on u_big: 6 stalls per 7 cycles
    drive(0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 0);
    b_valid = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("big_first_period_cnt", 32'(b_stall_cycles), 32'd6);
    repeat (76468 - 7) @(posedge clk);
    @(negedge clk);
    chk("big_saturated_cnt", 32'(b_stall_cycles), 32'hFFFF);
    chk("idle_cnt_held", 32'(stall_cycles), 32'd2);
    next_cycle();

    // Reset in the middle of a load-use stall
    drive(1, 5'd0, 5'd0, 2'b00, 5'd3, 1, 1, 0);
    next_cycle();
    drive(1, 5'd0, 5'd3, 2'b01, 5'd0, 0, 0, 0);
    @(negedge clk);
    chk("pre_reset_stall", 32'(stall), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_reset_stall", 32'(stall), 32'd0);
    chk("mid_reset_fwd", 32'(fwd_sel), 32'd0);
    chk("mid_reset_cnt", 32'(stall_cycles), 32'd0);
    chk("mid_reset_big_cnt", 32'(b_stall_cycles), 32'd0);
    chk("mid_reset_big_stall", 32'(b_stall), 32'd0);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_stall", 32'(stall), 32'd0);
    chk("post_reset_fwd", 32'(fwd_sel), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
